// File: rtl/hazard_ctrl.sv
// hazard_ctrl: central pipeline sequencing for the 5-stage MIPS pipeline.
// Resolves memory freezes, branch/jump squashes and load-use stalls in one
// priority chain and keeps saturating stall/flush counters for debug.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_jump,
    input  logic             ex_MemRead,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             pipe_freeze,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic [1:0]       pc_sel,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]  flush_q, flush_d;

    logic frz, wdog, freeze, load_use, flush_win;

    // Hazard detection: raw memory freeze, watchdog override, load-use match.
    always_comb begin
        frz      = mem_req & ~mem_ready;
        wdog     = (state_q == MEM_WAIT) & frz & (wait_cnt_q == WC_LAST);
        freeze   = frz & ~wdog;
        load_use = ex_MemRead & (ex_rt != 5'd0) &
                   ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

    // Control outputs: reset forces a plain advance, otherwise priority chain
    // freeze > branch > jump > load-use > normal advance.
    always_comb begin
        PCWrite     = 1'b1;
        IFIDWrite   = 1'b1;
        IDEXBubble  = 1'b0;
        pipe_freeze = 1'b0;
        IFIDFlush   = 1'b0;
        IDEXFlush   = 1'b0;
        EXMEMFlush  = 1'b0;
        pc_sel      = 2'b00;
        flush_win   = 1'b0;
        if (!reset) begin
            if (freeze) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                pipe_freeze = 1'b1;
            end else if (mem_branch_taken) begin
                IFIDFlush  = 1'b1;
                IDEXFlush  = 1'b1;
                EXMEMFlush = 1'b1;
                pc_sel     = 2'b01;
                flush_win  = 1'b1;
            end else if (id_jump) begin
                IFIDFlush = 1'b1;
                pc_sel    = 2'b10;
                flush_win = 1'b1;
            end else if (load_use) begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                IDEXBubble = 1'b1;
            end
        end
    end

    // Next-state: memory-wait tracking, sticky watchdog error, saturating counters.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q | wdog;
        stall_d    = stall_q;
        flush_d    = flush_q;
        case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WC_W'(1);
                end
            end
            MEM_WAIT: begin
                // Watchdog expiry, mem_ready and a dropped mem_req all end the wait.
                if (freeze) begin
                    wait_cnt_d = wait_cnt_q + WC_W'(1);
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (!PCWrite && !reset && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
        if (flush_win && (flush_q != {CNT_W{1'b1}}))
            flush_d = flush_q + CNT_W'(1);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with TIMEOUT=4, CNT_W=2 so the watchdog and
// counter saturation are reachable in a few cycles.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, id_jump, ex_MemRead, mem_branch_taken, mem_req, mem_ready;
    logic       PCWrite, IFIDWrite, IDEXBubble, pipe_freeze, IFIDFlush, IDEXFlush, EXMEMFlush;
    logic [1:0] pc_sel;
    logic       mem_err;
    logic [1:0] stall_cycles, flush_events;

    int errors = 0;
    int checks = 0;

    // {PCWrite, IFIDWrite, IDEXBubble, pipe_freeze, IFIDFlush, IDEXFlush, EXMEMFlush, pc_sel}
    logic [8:0] ctl;
    assign ctl = {PCWrite, IFIDWrite, IDEXBubble, pipe_freeze, IFIDFlush, IDEXFlush, EXMEMFlush, pc_sel};

    localparam logic [8:0] NORM  = 9'b1_1_0_0_0_0_0_00;
    localparam logic [8:0] STALL = 9'b0_0_1_0_0_0_0_00;
    localparam logic [8:0] FRZ   = 9'b0_0_0_1_0_0_0_00;
    localparam logic [8:0] BR    = 9'b1_0_0_0_1_1_1_01;  // IFIDWrite masked
    localparam logic [8:0] JMP   = 9'b1_0_0_0_1_0_0_10;  // IFIDWrite masked
    localparam logic [8:0] NOIFW = 9'b1_0_1_1_1_1_1_11;  // mask dropping IFIDWrite

    hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
        .ex_MemRead(ex_MemRead), .ex_rt(ex_rt), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXBubble(IDEXBubble),
        .pipe_freeze(pipe_freeze), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
        .EXMEMFlush(EXMEMFlush), .pc_sel(pc_sel), .mem_err(mem_err),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_uses_rt = 0; id_jump = 0; ex_MemRead = 0;
        mem_branch_taken = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        ex_MemRead = 1; ex_rt = 5; id_rs = 5; mem_branch_taken = 1; mem_req = 1;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", ctl, NORM); end
        tick();
        idle();
        reset = 0;
        #1;
        checks++; if (stall_cycles !== 2'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
        checks++; if (flush_events !== 2'd0) begin errors++; $display("FAIL reset_flush got=%0d exp=0", flush_events); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_MemRead = 1; ex_rt = 5; id_rs = 5;
        #1;
        checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_stall got=%b exp=%b", ctl, STALL); end
        tick();
        idle();
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_release got=%b exp=%b", ctl, NORM); end
        checks++; if (stall_cycles !== 2'd1) begin errors++; $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cycles); end
        ex_MemRead = 1; ex_rt = 0; id_rs = 0;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_r0 got=%b exp=%b", ctl, NORM); end
        ex_rt = 7; id_rs = 3; id_rt = 7; id_uses_rt = 1;
        #1;
        checks++; if (ctl !== STALL) begin errors++; $display("FAIL lu_rt got=%b exp=%b", ctl, STALL); end
        id_uses_rt = 0;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL lu_rt_unused got=%b exp=%b", ctl, NORM); end
        tick();
        checks++; if (stall_cycles !== 2'd1) begin errors++; $display("FAIL lu_stall_cnt2 got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        ex_MemRead = 1; ex_rt = 5; id_rs = 5; mem_branch_taken = 1;
        #1;
        checks++; if ((ctl & NOIFW) !== BR) begin errors++; $display("FAIL br_out got=%b exp=%b", ctl & NOIFW, BR); end
        tick();
        checks++; if (flush_events !== 2'd1) begin errors++; $display("FAIL br_flush_cnt got=%0d exp=1", flush_events); end
        checks++; if (stall_cycles !== 2'd0) begin errors++; $display("FAIL br_stall_cnt got=%0d exp=0", stall_cycles); end
        mem_branch_taken = 0; id_jump = 1;
        #1;
        checks++; if ((ctl & NOIFW) !== JMP) begin errors++; $display("FAIL jmp_over_lu got=%b exp=%b", ctl & NOIFW, JMP); end
        tick();
        checks++; if (flush_events !== 2'd2) begin errors++; $display("FAIL jmp_flush_cnt got=%0d exp=2", flush_events); end
        checks++; if (stall_cycles !== 2'd0) begin errors++; $display("FAIL jmp_stall_cnt got=%0d exp=0", stall_cycles); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== FRZ) begin errors++; $display("FAIL mw_freeze cyc=%0d got=%b exp=%b", i, ctl, FRZ); end
            tick();
        end
        mem_ready = 1;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL mw_release got=%b exp=%b", ctl, NORM); end
        tick();
        checks++; if (stall_cycles !== 2'd3) begin errors++; $display("FAIL mw_stall_cnt got=%0d exp=3", stall_cycles); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mw_mem_err got=%b exp=0", mem_err); end
        // Back in RUN with a fresh wait count: a new 3-cycle wait must not trip the watchdog.
        mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== FRZ) begin errors++; $display("FAIL mw2_freeze cyc=%0d got=%b exp=%b", i, ctl, FRZ); end
            tick();
        end
        mem_ready = 1;
        tick();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mw2_mem_err got=%b exp=0", mem_err); end
        // Ready in the first cycle of a request: no freeze.
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL mw_zero_wait got=%b exp=%b", ctl, NORM); end
        idle();
        tick();
    endtask

    task automatic test_watchdog();
        do_reset();
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== FRZ) begin errors++; $display("FAIL wd_freeze cyc=%0d got=%b exp=%b", i, ctl, FRZ); end
            tick();
        end
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL wd_forced_release got=%b exp=%b", ctl, NORM); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL wd_err_early got=%b exp=0", mem_err); end
        tick();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL wd_err_set got=%b exp=1", mem_err); end
        idle();
        tick(); tick();
        checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL wd_err_sticky got=%b exp=1", mem_err); end
        do_reset();
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL wd_err_reset got=%b exp=0", mem_err); end
    endtask

    task automatic test_priorities();
        do_reset();
        mem_req = 1; mem_ready = 0; mem_branch_taken = 1;
        #1;
        checks++; if (ctl !== FRZ) begin errors++; $display("FAIL pr_frz_br got=%b exp=%b", ctl, FRZ); end
        tick();
        checks++; if (flush_events !== 2'd0) begin errors++; $display("FAIL pr_frz_flush_cnt got=%0d exp=0", flush_events); end
        mem_ready = 1;
        #1;
        checks++; if ((ctl & NOIFW) !== BR) begin errors++; $display("FAIL pr_release_br got=%b exp=%b", ctl & NOIFW, BR); end
        tick();
        checks++; if (flush_events !== 2'd1) begin errors++; $display("FAIL pr_release_flush_cnt got=%0d exp=1", flush_events); end
        idle();
        mem_branch_taken = 1; id_jump = 1;
        #1;
        checks++; if ((ctl & NOIFW) !== BR) begin errors++; $display("FAIL pr_br_jmp got=%b exp=%b", ctl & NOIFW, BR); end
        mem_branch_taken = 0; mem_req = 1; mem_ready = 0;
        #1;
        checks++; if (ctl !== FRZ) begin errors++; $display("FAIL pr_frz_jmp got=%b exp=%b", ctl, FRZ); end
        idle();
        tick();
    endtask

    task automatic test_reset_sat();
        do_reset();
        mem_req = 1; mem_ready = 0;
        tick(); tick();
        reset = 1;
        #1;
        checks++; if (ctl !== NORM) begin errors++; $display("FAIL rs_forced_out got=%b exp=%b", ctl, NORM); end
        tick();
        reset = 0; idle();
        #1;
        checks++; if (stall_cycles !== 2'd0) begin errors++; $display("FAIL rs_stall got=%0d exp=0", stall_cycles); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rs_mem_err got=%b exp=0", mem_err); end
        // A wait count left over from before reset would trip the watchdog early.
        mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (ctl !== FRZ) begin errors++; $display("FAIL rs_run_freeze cyc=%0d got=%b exp=%b", i, ctl, FRZ); end
            tick();
        end
        do_reset();
        ex_MemRead = 1; ex_rt = 9; id_rs = 9;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (stall_cycles !== 2'd3) begin errors++; $display("FAIL sat_stall got=%0d exp=3", stall_cycles); end
        idle();
        id_jump = 1;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (flush_events !== 2'd3) begin errors++; $display("FAIL sat_flush got=%0d exp=3", flush_events); end
        idle();
    endtask

    initial begin
        idle();
        reset = 1;
        test_reset();
        test_load_use();
        test_branch_jump();
        test_mem_wait();
        test_watchdog();
        test_priorities();
        test_reset_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS pipeline. It sits beside `ctrl_unit` and the pipeline registers, and drives every write-enable, flush and PC-select decision from one place:

- load-use stalls;
- branch and jump squashes;
- whole-pipeline freezes while data memory is busy, with a watchdog on the memory handshake.

It also keeps saturating stall and flush counters for performance debug.

## Interface

Parameters:
- TIMEOUT, 16: maximum consecutive frozen cycles waiting on `mem_ready` before forced release (≥2).
- CNT_W, 16: width of the performance counters.

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq/bne, sw).
- id_jump  in  1  `jump` from `ctrl_unit` for the ID instruction.
- ex_MemRead  in  1  MemRead of the instruction in EX.
- ex_rt  in  5  destination rt of the instruction in EX.
- mem_branch_taken  in  1  branch in MEM resolved taken.
- mem_req  in  1  instruction in MEM accesses data memory (MemRead|MemWrite).
- mem_ready  in  1  data memory completes the access this cycle.
- PCWrite  out  1  PC update enable.
- IFIDWrite  out  1  IF/ID register enable.
- IDEXBubble  out  1  zero all control bits loaded into ID/EX.
- pipe_freeze  out  1  hold ID/EX and EX/MEM; load a bubble into MEM/WB.
- IFIDFlush  out  1  clear IF/ID.
- IDEXFlush  out  1  clear ID/EX.
- EXMEMFlush  out  1  clear EX/MEM.
- pc_sel  out  2  00 = PC+4, 01 = branch target, 10 = jump target.
- mem_err  out  1  sticky: watchdog expired.
- stall_cycles  out  CNT_W  cycles with PCWrite=0, saturating.
- flush_events  out  CNT_W  branch plus jump squash events, saturating.

## Operation

**States.**
- RUN: normal operation.
- MEM_WAIT: pipeline frozen on memory.
- Registers: `wait_cnt` (log2(TIMEOUT) bits), `mem_err`, and the two counters.

**Freeze condition.** `frz = mem_req & ~mem_ready` in either state. The watchdog overrides it, see MEM_WAIT.

**Decision priority** (all outputs are combinational from state + inputs; highest priority first):
1. Freeze. Outputs: PCWrite=0, IFIDWrite=0, pipe_freeze=1. All flushes 0, IDEXBubble=0, pc_sel=00. `mem_branch_taken` and `id_jump` are ignored.
2. Branch (`mem_branch_taken`). Outputs: IFIDFlush=1, IDEXFlush=1, EXMEMFlush=1, pc_sel=01, PCWrite=1. The load-use check is suppressed.
3. Jump (`id_jump`). Outputs: IFIDFlush=1, pc_sel=10, PCWrite=1. No load-use check, because a jump reads no registers.
4. Load-use. Condition: `ex_MemRead & ex_rt≠0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt))`. Outputs: PCWrite=0, IFIDWrite=0, IDEXBubble=1 for exactly one cycle. The hazard clears naturally as the load advances.
5. Otherwise: PCWrite=1, IFIDWrite=1, everything else 0, pc_sel=00.

**State transitions.**
- RUN → MEM_WAIT when `frz`; `wait_cnt` becomes 1.
- MEM_WAIT → RUN when `mem_ready=1`. That cycle is a normal advance: outputs follow priorities 2–5 and `wait_cnt` becomes 0.
- MEM_WAIT with `wait_cnt==TIMEOUT-1` and `mem_ready=0`:
  - set `mem_err`;
  - force release: outputs as if not frozen, priorities 2–5;
  - go to RUN and clear `wait_cnt`.
- Otherwise in MEM_WAIT: `wait_cnt` increments.
- `mem_req` dropping to 0 while in MEM_WAIT is treated as completion: go to RUN.

**Counters.**
- `stall_cycles` increments on every cycle with PCWrite=0 and reset=0.
- `flush_events` increments on every cycle in which priority 2 or 3 wins.
- Both hold at 2^CNT_W−1.
- `mem_err` clears only on reset.

## Timing

- **Reset** (synchronous): state=RUN, `wait_cnt`=0, `mem_err`=0, `stall_cycles`=0, `flush_events`=0. While reset=1, outputs are forced to PCWrite=1, IFIDWrite=1, all flush/bubble/freeze=0, pc_sel=00.
- **Reset mid-freeze:** the next cycle is RUN with counters at 0.
- **Latency:** zero-cycle (combinational) for every control output. Registered state takes effect the next cycle.
- **Load-use:** costs exactly 1 stall cycle; branch costs 3 squashed slots; jump costs 1 squashed slot.
- **Memory access:** `mem_ready` high in the first cycle of `mem_req` means no freeze. Each cycle of delay adds one frozen cycle, up to TIMEOUT−1 frozen cycles before forced release.
- **Simultaneous events:**
  - freeze + branch: freeze only; the branch is evaluated when the freeze releases.
  - branch + jump: branch only.
  - load-use + jump: jump only.

## Test plan

1. **Load-use:** ex_MemRead=1, ex_rt=5, id_rs=5, no other events → one cycle of PCWrite=0, IFIDWrite=0, IDEXBubble=1; stall_cycles=1. Repeat with ex_rt=0 → no stall.
2. **Branch:** mem_branch_taken=1 alongside the load-use condition → IFIDFlush=IDEXFlush=EXMEMFlush=1, pc_sel=01, PCWrite=1, flush_events=1, stall_cycles unchanged.
3. **Memory wait:** mem_req=1, mem_ready low for 3 cycles then high → pipe_freeze=1 for exactly 3 cycles, state returns to RUN, stall_cycles=3, mem_err=0.
4. **Watchdog:** TIMEOUT=4, mem_req=1, mem_ready held 0 → freeze for 3 cycles, release on the 4th, mem_err=1 and sticky until reset.
5. **Priorities:** freeze+branch → pc_sel=00, no flush. Then mem_ready=1 with the branch still asserted → flushes and pc_sel=01 that cycle. Jump+branch → pc_sel=01.
6. **Reset and saturation:** assert reset during MEM_WAIT → next cycle RUN, counters 0, mem_err 0. With CNT_W=2, 5 stalls → stall_cycles=3.
